// File: rtl/cnt_d_cal_if.sv
// -----------------------------------------------------------------------------
// cnt_d_cal_if
// Purpose : bundles the day counter's tick/button/calendar inputs and its
//           day/carry/calendar outputs so the counter and its neighbours
//           connect through one port.
// Modports:
//   master - drives pulse_1d, increase_d, decrease_d, enable_cnt_d,
//            cnt_y_ten_unit, cnt_century, cnt_mo; observes cnt_d, pulse_1mo,
//            day_total_in_mo, leap_yr
//   slave  - the day counter itself (mirror of master)
// -----------------------------------------------------------------------------
interface cnt_d_cal_if #(
    parameter int YEAR_W  = 7,
    parameter int MONTH_W = 7,
    parameter int DAY_W   = 6
) ();
    logic               pulse_1d;
    logic               increase_d;
    logic               decrease_d;
    logic               enable_cnt_d;
    logic [YEAR_W-1:0]  cnt_y_ten_unit;
    logic [6:0]         cnt_century;
    logic [MONTH_W-1:0] cnt_mo;
    logic [DAY_W-1:0]   cnt_d;
    logic               pulse_1mo;
    logic [DAY_W-1:0]   day_total_in_mo;
    logic               leap_yr;

    modport master (
        output pulse_1d, increase_d, decrease_d, enable_cnt_d,
               cnt_y_ten_unit, cnt_century, cnt_mo,
        input  cnt_d, pulse_1mo, day_total_in_mo, leap_yr
    );

    modport slave (
        input  pulse_1d, increase_d, decrease_d, enable_cnt_d,
               cnt_y_ten_unit, cnt_century, cnt_mo,
        output cnt_d, pulse_1mo, day_total_in_mo, leap_yr
    );
endinterface

// File: rtl/cnt_d_cal.sv
// -----------------------------------------------------------------------------
// cnt_d_cal
// Purpose : day-of-month counter of the century clock. In run mode it
//           advances on the daily tick and emits a one-cycle month carry on
//           wrap; in set mode it steps with edge-detected up/down buttons
//           that auto-repeat while held. The day is clamped down whenever
//           the month or year changes under it.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - cnt_d_cal_if.slave: pulse_1d, increase_d, decrease_d,
//          enable_cnt_d, cnt_y_ten_unit, cnt_century, cnt_mo in;
//          cnt_d, pulse_1mo, day_total_in_mo, leap_yr out
// Config  : define LEAP_CENTURY_EN to apply the full Gregorian rule using
//           cnt_century; otherwise every year divisible by 4 is leap.
// -----------------------------------------------------------------------------
module cnt_d_cal #(
    parameter int YEAR_W      = 7,
    parameter int MONTH_W     = 7,
    parameter int DAY_W       = 6,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100
) (
    input  logic         clk,
    input  logic         rst,
    cnt_d_cal_if.slave   bus
);

    // Hold counters count down to zero, so they only need to reach the
    // larger of the two reload values minus one.
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HOLD_W  = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [HOLD_W-1:0] DLY_LOAD  = HOLD_W'(REPEAT_DLY - 1);
    localparam logic [HOLD_W-1:0] RATE_LOAD = HOLD_W'(REPEAT_RATE - 1);
    localparam logic [DAY_W-1:0]  DAY_ONE   = DAY_W'(1);

    logic [DAY_W-1:0]  cnt_d_q, cnt_d_d;
    logic              pulse_1mo_q, pulse_1mo_d;
    logic              inc_prev_q, inc_prev_d;
    logic              dec_prev_q, dec_prev_d;
    logic              inc_arm_q, inc_arm_d;
    logic              dec_arm_q, dec_arm_d;
    logic [HOLD_W-1:0] inc_hold_q, inc_hold_d;
    logic [HOLD_W-1:0] dec_hold_q, dec_hold_d;

    logic              leap;
    logic [DAY_W-1:0]  day_total;
    logic              step_up;
    logic              step_dn;

`ifdef LEAP_CENTURY_EN
    logic [15:0] full_year;

    always_comb begin
        full_year = 16'(bus.cnt_century) * 16'd100 + 16'(bus.cnt_y_ten_unit);
        leap      = ((full_year % 16'd4 == 16'd0) && (full_year % 16'd100 != 16'd0))
                    || (full_year % 16'd400 == 16'd0);
    end
`else
    always_comb begin
        leap = ((bus.cnt_y_ten_unit % YEAR_W'(4)) == '0);
    end
`endif

    // Month length; illegal month codes fall back to 31 so the counter
    // never clamps below a real day.
    always_comb begin
        case (bus.cnt_mo)
            MONTH_W'(2):  day_total = leap ? DAY_W'(29) : DAY_W'(28);
            MONTH_W'(4),
            MONTH_W'(6),
            MONTH_W'(9),
            MONTH_W'(11): day_total = DAY_W'(30);
            default:      day_total = DAY_W'(31);
        endcase
    end

    // Next-state: run-mode ticking, set-mode button stepping with
    // auto-repeat, and clamping when nothing else moves the day.
    // The previous-level registers always track the buttons, so a button
    // already held when set mode is entered does not look like a new press.
    always_comb begin
        cnt_d_d     = cnt_d_q;
        pulse_1mo_d = 1'b0;
        inc_prev_d  = bus.increase_d;
        dec_prev_d  = bus.decrease_d;
        inc_arm_d   = 1'b0;
        dec_arm_d   = 1'b0;
        inc_hold_d  = '0;
        dec_hold_d  = '0;
        step_up     = 1'b0;
        step_dn     = 1'b0;

        if (bus.enable_cnt_d) begin
            if (bus.pulse_1d) begin
                if (cnt_d_q >= day_total) begin
                    cnt_d_d     = DAY_ONE;
                    pulse_1mo_d = 1'b1;
                end else begin
                    cnt_d_d = cnt_d_q + DAY_ONE;
                end
            end else if (cnt_d_q > day_total) begin
                cnt_d_d = day_total;
            end
        end else begin
            if (bus.increase_d && !bus.decrease_d) begin
                if (!inc_prev_q) begin
                    step_up    = 1'b1;
                    inc_arm_d  = 1'b1;
                    inc_hold_d = DLY_LOAD;
                end else if (inc_arm_q) begin
                    inc_arm_d = 1'b1;
                    if (inc_hold_q == '0) begin
                        step_up    = 1'b1;
                        inc_hold_d = RATE_LOAD;
                    end else begin
                        inc_hold_d = inc_hold_q - 1'b1;
                    end
                end
            end

            if (bus.decrease_d && !bus.increase_d) begin
                if (!dec_prev_q) begin
                    step_dn    = 1'b1;
                    dec_arm_d  = 1'b1;
                    dec_hold_d = DLY_LOAD;
                end else if (dec_arm_q) begin
                    dec_arm_d = 1'b1;
                    if (dec_hold_q == '0) begin
                        step_dn    = 1'b1;
                        dec_hold_d = RATE_LOAD;
                    end else begin
                        dec_hold_d = dec_hold_q - 1'b1;
                    end
                end
            end

            if (step_up) begin
                cnt_d_d = (cnt_d_q >= day_total) ? DAY_ONE : cnt_d_q + DAY_ONE;
            end else if (step_dn) begin
                if (cnt_d_q <= DAY_ONE || cnt_d_q > day_total) begin
                    cnt_d_d = day_total;
                end else begin
                    cnt_d_d = cnt_d_q - DAY_ONE;
                end
            end else if (cnt_d_q > day_total) begin
                cnt_d_d = day_total;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_d_q     <= DAY_ONE;
            pulse_1mo_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
            inc_arm_q   <= 1'b0;
            dec_arm_q   <= 1'b0;
            inc_hold_q  <= '0;
            dec_hold_q  <= '0;
        end else begin
            cnt_d_q     <= cnt_d_d;
            pulse_1mo_q <= pulse_1mo_d;
            inc_prev_q  <= inc_prev_d;
            dec_prev_q  <= dec_prev_d;
            inc_arm_q   <= inc_arm_d;
            dec_arm_q   <= dec_arm_d;
            inc_hold_q  <= inc_hold_d;
            dec_hold_q  <= dec_hold_d;
        end
    end

    assign bus.cnt_d           = cnt_d_q;
    assign bus.pulse_1mo       = pulse_1mo_q;
    assign bus.day_total_in_mo = day_total;
    assign bus.leap_yr         = leap;

endmodule
